// File: rtl/stepper_sequencer_if.sv
// Move-request / status bundle for stepper_sequencer.
//   master : requester side, drives dir/half/stop/move_req/move_steps and
//            observes move_ack/busy/done plus the coil, phase and position outputs.
//   slave  : the sequencer itself.
interface stepper_sequencer_if #(
  parameter int unsigned POS_W = 16
) ();
  logic             dir;
  logic             half;
  logic             stop;
  logic             move_req;
  logic [POS_W-1:0] move_steps;
  logic             move_ack;
  logic             busy;
  logic             done;
  logic [3:0]       coils;
  logic [2:0]       phase;
  logic [POS_W-1:0] position;

  modport master (
    output dir, half, stop, move_req, move_steps,
    input  move_ack, busy, done, coils, phase, position
  );

  modport slave (
    input  dir, half, stop, move_req, move_steps,
    output move_ack, busy, done, coils, phase, position
  );
endinterface

// File: rtl/stepper_sequencer.sv
// 4-phase stepper sequencer: turns move requests into coil patterns for GPIO[3:0].
// Each accepted move runs move_steps steps, paced at one step per STEP_DIV clocks.
// Direction and step mode are latched when the move is accepted. The stop input
// pauses a running move, and done pulses once when the move completes.
// Ports:
//   CLOCK_50 : system clock, rising edge
//   Clear_b  : asynchronous active-low reset
//   bus      : slave side of stepper_sequencer_if
//              (requests in; ack/busy/done/coils/phase/position out)
module stepper_sequencer #(
  parameter int unsigned STEP_DIV = 50_000,
  parameter int unsigned POS_W    = 16
) (
  input  logic                  CLOCK_50,
  input  logic                  Clear_b,
  stepper_sequencer_if.slave    bus
);

  localparam int unsigned DIV_W = $clog2(STEP_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [2:0]       phase_q, phase_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [POS_W-1:0] rem_q, rem_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             energized_q, energized_d;
  logic             dir_q, dir_d;
  logic             half_q, half_d;
  logic             ack_q, ack_d;

  logic [2:0]       phase_delta;
  logic [2:0]       phase_step;
  logic             step_edge;
  logic [3:0]       coil_pat;

  // Full-step mode moves by 2 on odd phases. An even phase left over from a
  // half-step move takes a single 1-step first, so later steps land on odd phases.
  assign phase_delta = (half_q || !phase_q[0]) ? 3'd1 : 3'd2;
  assign phase_step  = dir_q ? phase_q + phase_delta : phase_q - phase_delta;
  assign step_edge   = (div_q == DIV_LAST);

  always_ff @(posedge CLOCK_50 or negedge Clear_b) begin
    if (!Clear_b) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      pos_q       <= '0;
      rem_q       <= '0;
      div_q       <= '0;
      energized_q <= 1'b0;
      dir_q       <= 1'b0;
      half_q      <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      pos_q       <= pos_d;
      rem_q       <= rem_d;
      div_q       <= div_d;
      energized_q <= energized_d;
      dir_q       <= dir_d;
      half_q      <= half_d;
      ack_q       <= ack_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    pos_d       = pos_q;
    rem_d       = rem_q;
    div_d       = div_q;
    energized_d = energized_q;
    dir_d       = dir_q;
    half_d      = half_q;
    ack_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.move_req && !bus.stop) begin
          ack_d  = 1'b1;
          dir_d  = bus.dir;
          half_d = bus.half;
          rem_d  = bus.move_steps;
          div_d  = '0;
          // A zero-length move finishes without ever energizing the coils.
          if (bus.move_steps == '0) begin
            state_d = S_DONE;
          end else begin
            energized_d = 1'b1;
            state_d     = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (step_edge) begin
          div_d   = '0;
          phase_d = phase_step;
          pos_d   = dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
          rem_d   = rem_q - POS_W'(1);
        end else begin
          div_d = div_q + DIV_W'(1);
        end
        // The last step completing takes priority over a pause request.
        if (step_edge && rem_q == POS_W'(1)) begin
          state_d = S_DONE;
        end else if (bus.stop) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!bus.stop) begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    coil_pat = 4'b0000;
    case (phase_q)
      3'd0: coil_pat = 4'b1000;
      3'd1: coil_pat = 4'b1100;
      3'd2: coil_pat = 4'b0100;
      3'd3: coil_pat = 4'b0110;
      3'd4: coil_pat = 4'b0010;
      3'd5: coil_pat = 4'b0011;
      3'd6: coil_pat = 4'b0001;
      3'd7: coil_pat = 4'b1001;
      default: coil_pat = 4'b0000;
    endcase
  end

  assign bus.coils    = energized_q ? coil_pat : 4'b0000;
  assign bus.phase    = phase_q;
  assign bus.position = pos_q;
  assign bus.move_ack = ack_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = (state_q == S_DONE);

endmodule
